// File: rtl/spart_bus_responder.sv
// ============================================================================
//  Module      : spart_bus_responder
//  Description : Memory-mapped register target for the SPART. Serves DATA,
//                STATUS and DIVISOR to the Dcache-side initiator, buffers
//                received bytes in an RX FIFO and holds one pending TX byte.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spart_bus_responder #(
  parameter int          RX_DEPTH     = 4,
  parameter int          RESP_LATENCY = 1,
  parameter logic [15:0] DIV_RESET    = 16'd325
) (
  input  logic        clk,
  input  logic        rst,
  // Initiator side
  input  logic        mem_valid,
  input  logic        mem_rw,
  input  logic [27:0] mem_addr,
  input  logic [31:0] mem_data_wr,
  output logic [31:0] mem_data_rd,
  output logic        mem_ready,
  // SPART core side
  input  logic [7:0]  rx_byte,
  input  logic        rx_strobe,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ack,
  output logic [15:0] baud_div
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_AW = $clog2(RX_DEPTH);
  localparam int c_CW = $clog2(RX_DEPTH) + 1;
  localparam int c_LW = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

  localparam logic [c_LW-1:0] c_LAT_LOAD = c_LW'(RESP_LATENCY - 1);
  localparam logic [c_CW-1:0] c_RX_FULL  = c_CW'(RX_DEPTH);

  localparam logic [27:0] c_ADDR_DATA    = 28'h8000000;
  localparam logic [27:0] c_ADDR_STATUS  = 28'h8000001;
  localparam logic [27:0] c_ADDR_DIVISOR = 28'h8000002;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_capture;
  logic              w_fire;
  logic              w_ready;

  logic              r_rw;
  logic [27:0]       r_addr;
  logic [15:0]       r_wdata;
  logic [c_LW-1:0]   r_lat_cnt;

  logic [7:0]        r_rx_mem [RX_DEPTH];
  logic [c_AW-1:0]   r_rx_wr_ptr;
  logic [c_AW-1:0]   r_rx_rd_ptr;
  logic [c_CW-1:0]   r_rx_count;
  logic              r_rx_ovr;
  logic              r_tx_ovf;
  logic [7:0]        r_tx_byte;
  logic              r_tx_valid;
  logic [15:0]       r_div;
  logic [31:0]       r_rdata;

  logic              w_sel_data;
  logic              w_sel_status;
  logic              w_sel_div;
  logic              w_rd;
  logic              w_wr;
  logic              w_rx_avail;
  logic              w_rx_full;
  logic              w_pop;
  logic              w_push;
  logic              w_rx_drop;
  logic              w_tx_wr;
  logic              w_tx_load;
  logic              w_tx_drop;
  logic              w_stat_rd;
  logic              w_div_wr;
  logic [31:0]       w_status;
  logic [31:0]       w_rd_mux;

  // Upper write-data bits have no destination register.
  logic              w_unused_ok;
  assign w_unused_ok = &{1'b0, mem_data_wr[31:16]};

  // --------------------------------------------------------------------------
  // Transaction FSM
  // --------------------------------------------------------------------------

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus capture/fire/ready strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_fire      = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_lat_cnt == '0) begin
          w_fire      = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_ready     = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // Wait for the initiator to drop valid so a held request is not re-run.
        if (!mem_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture on acceptance and latency countdown while in ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lat_cnt <= '0;
    end else if (w_capture) begin
      r_rw      <= mem_rw;
      r_addr    <= mem_addr;
      r_wdata   <= mem_data_wr[15:0];
      r_lat_cnt <= c_LAT_LOAD;
    end else if ((r_state == S_ACCESS) && (r_lat_cnt != '0)) begin
      r_lat_cnt <= r_lat_cnt - c_LW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Decode and side-effect strobes (all qualified by the ACCESS->RESP edge)
  // --------------------------------------------------------------------------
  assign w_sel_data   = (r_addr == c_ADDR_DATA);
  assign w_sel_status = (r_addr == c_ADDR_STATUS);
  assign w_sel_div    = (r_addr == c_ADDR_DIVISOR);

  assign w_rd         = w_fire & ~r_rw;
  assign w_wr         = w_fire &  r_rw;

  assign w_rx_avail   = (r_rx_count != '0);
  assign w_rx_full    = (r_rx_count == c_RX_FULL);

  // A pop frees a slot in the same cycle, so a push into a full FIFO survives.
  assign w_pop        = w_rd & w_sel_data & w_rx_avail;
  assign w_push       = rx_strobe & (~w_rx_full | w_pop);
  assign w_rx_drop    = rx_strobe & w_rx_full & ~w_pop;

  // A write alongside tx_ack replaces the byte being consumed.
  assign w_tx_wr      = w_wr & w_sel_data;
  assign w_tx_load    = w_tx_wr & (~r_tx_valid | tx_ack);
  assign w_tx_drop    = w_tx_wr & r_tx_valid & ~tx_ack;

  assign w_stat_rd    = w_rd & w_sel_status;
  assign w_div_wr     = w_wr & w_sel_div;

  assign w_status     = {28'b0, r_tx_ovf, r_rx_ovr, w_rx_avail, ~r_tx_valid};

  // Read-data selection; writes and unmapped addresses return zero.
  always_comb begin
    w_rd_mux = '0;
    if (!r_rw) begin
      if (w_sel_data) begin
        if (w_rx_avail) begin
          w_rd_mux = {24'b0, r_rx_mem[r_rx_rd_ptr]};
        end
      end else if (w_sel_status) begin
        w_rd_mux = w_status;
      end else if (w_sel_div) begin
        w_rd_mux = {16'b0, r_div};
      end
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------

  // Storage array; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rx_mem[r_rx_wr_ptr] <= rx_byte;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_push) begin
        r_rx_wr_ptr <= r_rx_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rx_rd_ptr <= r_rx_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_rx_count <= r_rx_count + c_CW'(1);
        2'b01:   r_rx_count <= r_rx_count - c_CW'(1);
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // Sticky overflow flags; a new overflow wins over a STATUS-read clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ovr <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_rx_drop) begin
        r_rx_ovr <= 1'b1;
      end else if (w_stat_rd) begin
        r_rx_ovr <= 1'b0;
      end
      if (w_tx_drop) begin
        r_tx_ovf <= 1'b1;
      end else if (w_stat_rd) begin
        r_tx_ovf <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX holding register
  // --------------------------------------------------------------------------

  // Load on accepted DATA write; acknowledge without a write empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_byte  <= '0;
      r_tx_valid <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_byte  <= r_wdata[7:0];
      r_tx_valid <= 1'b1;
    end else if (tx_ack) begin
      r_tx_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // DIVISOR register and response data
  // --------------------------------------------------------------------------

  // Baud divisor, low half-word of the write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= DIV_RESET;
    end else if (w_div_wr) begin
      r_div <= r_wdata;
    end
  end

  // Response data is loaded once per transaction and held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_fire) begin
      r_rdata <= w_rd_mux;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_ready   = w_ready;
  assign mem_data_rd = r_rdata;
  assign tx_byte     = r_tx_byte;
  assign tx_valid    = r_tx_valid;
  assign baud_div    = r_div;

endmodule

`default_nettype wire

// File: tb/tb_spart_bus_responder.sv
// ============================================================================
//  Module      : tb_spart_bus_responder
//  Description : Directed self-checking bench for spart_bus_responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spart_bus_responder;

  localparam logic [27:0] c_DATA   = 28'h8000000;
  localparam logic [27:0] c_STATUS = 28'h8000001;
  localparam logic [27:0] c_DIV    = 28'h8000002;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_rw;
  logic [27:0] mem_addr;
  logic [31:0] mem_data_wr;
  logic [31:0] mem_data_rd;
  logic        mem_ready;
  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ack;
  logic [15:0] baud_div;

  int          n_checks;
  int          n_fail;
  logic [31:0] rd;
  int          lat;
  int          n_ready;
  logic        got;

  spart_bus_responder #(
    .RX_DEPTH     (4),
    .RESP_LATENCY (1),
    .DIV_RESET    (16'd325)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_rw      (mem_rw),
    .mem_addr    (mem_addr),
    .mem_data_wr (mem_data_wr),
    .mem_data_rd (mem_data_rd),
    .mem_ready   (mem_ready),
    .rx_byte     (rx_byte),
    .rx_strobe   (rx_strobe),
    .tx_byte     (tx_byte),
    .tx_valid    (tx_valid),
    .tx_ack      (tx_ack),
    .baud_div    (baud_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; inputs change and outputs are sampled on negedges.
  task automatic bus_xact(input logic rw, input logic [27:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_valid   = 1'b1;
    mem_rw      = rw;
    mem_addr    = addr;
    mem_data_wr = wdata;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (mem_ready) begin
        seen  = 1'b1;
        rdata = mem_data_rd;
      end
    end
    check_eq("ready_seen", {31'b0, seen}, 32'h1);
    mem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte   = b;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    mem_valid   = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_data_wr = '0;
    rx_byte     = '0;
    rx_strobe   = 1'b0;
    tx_ack      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1. reset state and first STATUS read
    check_eq("rst_ready", {31'b0, mem_ready}, 32'h0);
    check_eq("rst_rdata", mem_data_rd, 32'h0);
    check_eq("rst_txv", {31'b0, tx_valid}, 32'h0);
    check_eq("rst_txb", {24'b0, tx_byte}, 32'h0);
    check_eq("rst_div", {16'b0, baud_div}, 32'd325);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t1_status", rd, 32'h1);
    check_eq("t1_latency", lat, 2);

    // 2. single RX byte
    push_byte(8'hA5);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t2_status", rd, 32'h3);
    bus_xact(1'b0, c_DATA, 32'h0, rd, lat);
    check_eq("t2_data", rd, 32'hA5);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t2_status2", rd, 32'h1);

    // 3. TX holding register and overflow
    bus_xact(1'b1, c_DATA, 32'h1234_5678, rd, lat);
    check_eq("t3_wr_rdata", rd, 32'h0);
    check_eq("t3_txv", {31'b0, tx_valid}, 32'h1);
    check_eq("t3_txb", {24'b0, tx_byte}, 32'h78);
    bus_xact(1'b1, c_DATA, 32'h0000_0099, rd, lat);
    check_eq("t3_txb_kept", {24'b0, tx_byte}, 32'h78);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t3_status_ovf", rd, 32'h8);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t3_status_clr", rd, 32'h0);
    @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    check_eq("t3_ack_clr", {31'b0, tx_valid}, 32'h0);

    // 3b. write landing in the same cycle as tx_ack replaces the byte
    bus_xact(1'b1, c_DATA, 32'h11, rd, lat);
    @(negedge clk);
    mem_valid   = 1'b1;
    mem_rw      = 1'b1;
    mem_addr    = c_DATA;
    mem_data_wr = 32'h22;
    @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    check_eq("t3b_ready", {31'b0, mem_ready}, 32'h1);
    check_eq("t3b_txv", {31'b0, tx_valid}, 32'h1);
    check_eq("t3b_txb", {24'b0, tx_byte}, 32'h22);
    mem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t3b_status", rd, 32'h0);
    @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;

    // 4. RX overflow
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t4_status", rd, 32'h7);
    for (int i = 1; i <= 4; i++) begin
      bus_xact(1'b0, c_DATA, 32'h0, rd, lat);
      check_eq("t4_pop", rd, 32'(i));
    end
    bus_xact(1'b0, c_DATA, 32'h0, rd, lat);
    check_eq("t4_empty_pop", rd, 32'h0);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t4_status2", rd, 32'h1);

    // 4b. push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) push_byte(8'(8'h10 + i));
    @(negedge clk);
    mem_valid = 1'b1;
    mem_rw    = 1'b0;
    mem_addr  = c_DATA;
    @(negedge clk);
    rx_byte   = 8'h14;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
    check_eq("t4b_ready", {31'b0, mem_ready}, 32'h1);
    check_eq("t4b_data", mem_data_rd, 32'h10);
    mem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t4b_status", rd, 32'h3);
    for (int i = 1; i <= 4; i++) begin
      bus_xact(1'b0, c_DATA, 32'h0, rd, lat);
      check_eq("t4b_drain", rd, 32'(8'h10 + i));
    end

    // 5. DIVISOR and unmapped addresses
    bus_xact(1'b1, c_DIV, 32'hFFFF_0010, rd, lat);
    check_eq("t5_baud", {16'b0, baud_div}, 32'h10);
    bus_xact(1'b0, c_DIV, 32'h0, rd, lat);
    check_eq("t5_div_rd", rd, 32'h10);
    bus_xact(1'b0, 28'h8000003, 32'h0, rd, lat);
    check_eq("t5_unmapped", rd, 32'h0);
    bus_xact(1'b1, c_STATUS, 32'hFFFF_FFFF, rd, lat);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t5_status_wr_ign", rd, 32'h1);

    // 6. valid held after ready: one response, one pop
    push_byte(8'h5A);
    push_byte(8'h5B);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_rw    = 1'b0;
    mem_addr  = c_DATA;
    n_ready   = 0;
    got       = 1'b0;
    rd        = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        n_ready++;
        rd = mem_data_rd;
      end
    end
    mem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_one_ready", n_ready, 1);
    check_eq("t6_data", rd, 32'h5A);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t6_status", rd, 32'h3);
    bus_xact(1'b0, c_DATA, 32'h0, rd, lat);
    check_eq("t6_data2", rd, 32'h5B);

    // 6b. reset during ACCESS aborts the transaction
    push_byte(8'h77);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_rw    = 1'b0;
    mem_addr  = c_DATA;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    mem_valid = 1'b0;
    n_ready   = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_ready) n_ready++;
      @(negedge clk);
    end
    check_eq("t6b_no_ready", n_ready, 0);
    check_eq("t6b_rdata", mem_data_rd, 32'h0);
    check_eq("t6b_div", {16'b0, baud_div}, 32'd325);
    bus_xact(1'b0, c_STATUS, 32'h0, rd, lat);
    check_eq("t6b_status", rd, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
